// File: rtl/router_pkt_ctrl.sv
// Router ingress controller: decodes the header address, streams bytes into the selected FIFO and checks parity.
// Define ROUTER_LEN_CHECK_EN to compare the payload beat count against the header length field (len_err).
//   state        | meaning
//   S_DECODE     | idle, waiting for a header with a valid address
//   S_WAIT_EMPTY | header latched, waiting for the target FIFO to drain
//   S_LFD        | header byte written to the FIFO
//   S_LOAD_DATA  | payload and parity bytes written as the FIFO allows
//   S_CHECK      | internal parity compared against the received parity byte
module router_pkt_ctrl #(
  parameter int DATA_W   = 8,
  parameter int NUM_DEST = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [NUM_DEST-1:0] fifo_full,
  input  logic [NUM_DEST-1:0] fifo_empty,
  input  logic [NUM_DEST-1:0] soft_reset,
  output logic [DATA_W-1:0] dout,
  output logic [NUM_DEST-1:0] write_enb,
  output logic              lfd_state,
  output logic              busy,
  output logic              err,
  output logic              parity_done,
  output logic              len_err
);

  typedef enum logic [2:0] {
    S_DECODE, S_WAIT_EMPTY, S_LFD, S_LOAD_DATA, S_CHECK
  } state_t;

  state_t r_state, w_next;

  logic [DATA_W-1:0]   r_hdr;
  logic [1:0]          r_addr;
  logic [DATA_W-1:0]   r_int_par;
  logic [DATA_W-1:0]   r_ext_par;
  logic                r_err;
  logic                r_parity_done;

  // Flags padded to four entries so the 2-bit address can index them directly.
  logic [3:0]          w_full_pad, w_empty_pad, w_sr_pad;
  logic                w_hdr_ok, w_abort, w_accept;
  logic [NUM_DEST-1:0] w_sel;

  assign w_full_pad  = {{(4-NUM_DEST){1'b0}}, fifo_full};
  assign w_empty_pad = {{(4-NUM_DEST){1'b0}}, fifo_empty};
  assign w_sr_pad    = {{(4-NUM_DEST){1'b0}}, soft_reset};

  assign w_hdr_ok = (r_state == S_DECODE) && pkt_valid && (data_in[1:0] != 2'd3);
  assign w_abort  = (r_state != S_DECODE) && w_sr_pad[r_addr];
  assign w_accept = (r_state == S_LOAD_DATA) && !w_full_pad[r_addr] && !w_abort;
  assign w_sel    = NUM_DEST'(1) << r_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_DECODE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_DECODE:     if (w_hdr_ok) w_next = w_empty_pad[data_in[1:0]] ? S_LFD : S_WAIT_EMPTY;
      S_WAIT_EMPTY: if (w_empty_pad[r_addr]) w_next = S_LFD;
      S_LFD:        w_next = S_LOAD_DATA;
      S_LOAD_DATA:  if (w_accept && !pkt_valid) w_next = S_CHECK;
      S_CHECK:      w_next = S_DECODE;
      default:      w_next = S_DECODE;
    endcase
    if (w_abort) w_next = S_DECODE;
  end

  always_comb begin
    write_enb = '0;
    lfd_state = 1'b0;
    busy      = 1'b0;
    dout      = '0;
    case (r_state)
      S_WAIT_EMPTY: busy = 1'b1;
      S_LFD: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        dout      = r_hdr;
        if (!w_abort) write_enb = w_sel;
      end
      S_LOAD_DATA: begin
        busy = w_full_pad[r_addr];
        dout = data_in;
        if (w_accept) write_enb = w_sel;
      end
      S_CHECK: busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hdr         <= '0;
      r_addr        <= '0;
      r_int_par     <= '0;
      r_ext_par     <= '0;
      r_err         <= 1'b0;
      r_parity_done <= 1'b0;
    end else begin
      r_parity_done <= (r_state == S_CHECK) && !w_abort;
      if (w_hdr_ok) begin
        r_hdr     <= data_in;
        r_addr    <= data_in[1:0];
        r_int_par <= data_in;
        r_err     <= 1'b0;
      end
      // The parity beat itself is captured, never folded into the running XOR.
      if (w_accept) begin
        if (pkt_valid) r_int_par <= r_int_par ^ data_in;
        else           r_ext_par <= data_in;
      end
      if ((r_state == S_CHECK) && !w_abort) r_err <= (r_int_par != r_ext_par);
    end
  end

  assign err         = r_err;
  assign parity_done = r_parity_done;

`ifdef ROUTER_LEN_CHECK_EN
  logic [5:0] r_pay_cnt;
  logic       r_len_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pay_cnt <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_hdr_ok) begin
        r_pay_cnt <= '0;
        r_len_err <= 1'b0;
      end else if (w_accept && pkt_valid) begin
        r_pay_cnt <= r_pay_cnt + 6'd1;
      end
      if ((r_state == S_CHECK) && !w_abort) r_len_err <= (r_pay_cnt != r_hdr[7:2]);
    end
  end

  assign len_err = r_len_err;
`else
  assign len_err = 1'b0;
`endif

endmodule
